// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch and
// load/store traffic, data first, one outstanding transaction at a time.
package mem_port_arbiter_pkg;
  parameter int cDataWidth  = 32;
  parameter int cRegSelBitW = 5;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [cDataWidth-1:0]  addr;
    logic [cDataWidth-1:0]  data;
    logic [2:0]             opType;
    logic [cRegSelBitW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
    logic [cDataWidth-1:0]  data;
  } tRegOp;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iFetchReq,
  input  logic [31:0] iFetchAddr,
  output logic        oFetchGnt,
  output logic        oFetchDv,
  output logic [31:0] oFetchData,
  input  logic        iFlush,
  input  tMemOp       iMemOp,
  output logic        oDataGnt,
  output logic        oMisalign,
  output tRegOp       oRegOp,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemBe,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData
);

  typedef enum logic [1:0] {IDLE, FETCH_WAIT, LOAD_WAIT, STORE_WAIT} tState;

  tState       r_state;
  logic        r_drop;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [2:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd_addr;
  logic        r_fetch_dv;
  logic [31:0] r_fetch_data;
  logic        r_misalign;
  tRegOp       r_reg_op;

  logic        w_data_req;
  logic        w_idle;
  logic        w_half;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;
  logic        w_unused;

  assign w_unused   = ^iFetchAddr[1:0];
  assign w_data_req = iMemOp.read | iMemOp.write;
  assign w_idle     = (r_state == IDLE);
  assign oDataGnt   = w_idle & w_data_req;
  assign oFetchGnt  = w_idle & ~w_data_req & iFetchReq;

  assign w_half     = (iMemOp.opType == 3'b001) | (iMemOp.opType == 3'b101);
  assign w_misalign = (w_half & iMemOp.addr[0]) |
                      ((iMemOp.opType == 3'b010) & (|iMemOp.addr[1:0]));
  assign w_wdata    = iMemOp.data << {iMemOp.addr[1:0], 3'b000};
  assign w_lane     = iMemRData >> {r_addr_lo, 3'b000};

  always_comb begin
    w_be = 4'b1111;
    case (iMemOp.opType)
      3'b000, 3'b100: w_be = 4'b0001 << iMemOp.addr[1:0];
      3'b001, 3'b101: w_be = 4'b0011 << iMemOp.addr[1:0];
      default:        w_be = 4'b1111;
    endcase
  end

  // Unlisted opTypes behave as a full-word access.
  always_comb begin
    w_load_data = iMemRData;
    case (r_op)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load_data = {24'h0, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load_data = {16'h0, w_lane[15:0]};
      default: w_load_data = iMemRData;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state      <= IDLE;
      r_drop       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_op         <= '0;
      r_addr_lo    <= '0;
      r_rd_addr    <= '0;
      r_fetch_dv   <= 1'b0;
      r_fetch_data <= '0;
      r_misalign   <= 1'b0;
      r_reg_op     <= '0;
    end else begin
      r_fetch_dv  <= 1'b0;
      r_misalign  <= 1'b0;
      r_reg_op.dv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_data_req) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= ~iMemOp.read;
              r_mem_addr  <= {iMemOp.addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_be    <= w_be;
              r_op        <= iMemOp.opType;
              r_addr_lo   <= iMemOp.addr[1:0];
              r_rd_addr   <= iMemOp.rdAddr;
              r_state     <= iMemOp.read ? LOAD_WAIT : STORE_WAIT;
            end
          end else if (iFetchReq) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {iFetchAddr[31:2], 2'b00};
            r_mem_wdata <= '0;
            r_mem_be    <= 4'b1111;
            r_drop      <= 1'b0;
            r_state     <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (iMemAck) begin
            r_mem_req <= 1'b0;
            r_drop    <= 1'b0;
            r_state   <= IDLE;
            // A flush in the ack cycle itself also kills the response.
            if (!r_drop && !iFlush) begin
              r_fetch_dv   <= 1'b1;
              r_fetch_data <= iMemRData;
            end
          end else if (iFlush) begin
            r_drop <= 1'b1;
          end
        end
        LOAD_WAIT: begin
          if (iMemAck) begin
            r_mem_req     <= 1'b0;
            r_state       <= IDLE;
            r_reg_op.dv   <= |r_rd_addr;
            r_reg_op.addr <= r_rd_addr;
            r_reg_op.data <= w_load_data;
          end
        end
        STORE_WAIT: begin
          if (iMemAck) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oMemReq    = r_mem_req;
  assign oMemWe     = r_mem_we;
  assign oMemAddr   = r_mem_addr;
  assign oMemWData  = r_mem_wdata;
  assign oMemBe     = r_mem_be;
  assign oFetchDv   = r_fetch_dv;
  assign oFetchData = r_fetch_data;
  assign oMisalign  = r_misalign;
  assign oRegOp     = r_reg_op;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction fetch stage and the execute stage's load/store requests (memOp field of the ALU output). Data accesses have fixed priority over fetches, one transaction is outstanding at a time, and a small FSM sequences each transaction. For loads, the block extracts the addressed byte/half/word, sign- or zero-extends it per funct3, and returns it as a register write-back (regOp). Fetch responses go back to the fetch stage and are discarded on a branch flush.

## Interface
- cDataWidth, 32, memory and register data width
- cRegSelBitW, 5, register address width
- iClk  in  1  core clock, all logic on rising edge
- iRstN  in  1  asynchronous active-low reset
- iFetchReq  in  1  fetch request; held with iFetchAddr until oFetchGnt
- iFetchAddr  in  32  fetch address (word aligned; bits [1:0] ignored)
- oFetchGnt  out  1  combinational grant of fetch request
- oFetchDv  out  1  one-cycle pulse: oFetchData valid
- oFetchData  out  32  fetched instruction word
- iFlush  in  1  branch flush; pending or same-cycle fetch response is dropped
- iMemOp  in  tMemOp  read/write/addr/data/opType/rdAddr; held until oDataGnt
- oDataGnt  out  1  combinational grant of data request
- oMisalign  out  1  one-cycle pulse: data request rejected as misaligned
- oRegOp  out  tRegOp  load write-back (dv, addr, data)
- oMemReq  out  1  memory request, held until iMemAck
- oMemWe  out  1  write enable
- oMemAddr  out  32  word address (bits [1:0] forced 0)
- oMemWData  out  32  store data, lane-shifted
- oMemBe  out  4  byte enables
- iMemAck  in  1  completes the current request in the same cycle
- iMemRData  in  32  read data, valid with iMemAck

## Operation
- States: IDLE, FETCH_WAIT, LOAD_WAIT, STORE_WAIT.
- IDLE, data request (iMemOp.read or .write; read wins if both set): oDataGnt=1, latch op, go LOAD_WAIT or STORE_WAIT.
- IDLE, no data request, iFetchReq=1: oFetchGnt=1, latch address, go FETCH_WAIT.
- Grants are asserted only in IDLE.
- Alignment check on data requests:
  - half access (opType 001/101) with addr[0]=1 → misaligned.
  - word access (010) with addr[1:0]≠0 → misaligned.
  - Misaligned request: oDataGnt=1, oMisalign pulses next cycle, no memory access, state stays IDLE.
- Byte enables by opType:
  - byte (000/100): 0001 << addr[1:0]
  - half (001/101): 0011 << addr[1:0]
  - word (010): 1111
  - any other opType: treated as word.
- oMemWData = data << 8·addr[1:0].
- In every WAIT state: oMemReq=1, with oMemWe/oMemAddr/oMemWData/oMemBe stable until iMemAck. On iMemAck, return to IDLE.
- LOAD_WAIT ack:
  - lane = iMemRData >> 8·addr[1:0].
  - 000 sign-extends lane[7:0]; 100 zero-extends lane[7:0]; 001 sign-extends lane[15:0]; 101 zero-extends lane[15:0]; 010 takes the full word.
  - oRegOp.dv=1 with addr=rdAddr, except rdAddr=0 gives dv=0.
- FETCH_WAIT:
  - iFlush sets a drop flag.
  - On ack, oFetchDv=1 only if the drop flag is clear and iFlush=0 that cycle. The flag clears on ack.
- STORE_WAIT ack: no response output.
- Reset (asynchronous, any state): IDLE, drop flag 0. All outputs 0: oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe, oFetchDv, oFetchData, oRegOp, oMisalign. An abandoned memory transaction is not resumed.

## Timing
- Grant in cycle N (combinational on requests, in IDLE). oMemReq=1 from N+1.
- Ack in cycle M≥N+1 → oRegOp.dv/oFetchDv pulse in M+1, registered, exactly one cycle. IDLE in M+1; the next grant is possible in M+1.
- Zero-wait memory (ack in first req cycle): one transaction per 2 cycles.
- oFetchGnt and oDataGnt are never high together. A fetch is never granted while a data request is present (data priority; fetch may starve).
- iFlush during IDLE with no pending fetch: no effect.

## Test plan
- Fetch: iFetchAddr=0x100, ack 2 cycles after req → oMemAddr=0x100, oMemBe=1111, oMemWe=0, oFetchDv pulse with data 0x00A00093 one cycle after ack.
- Simultaneous fetch + load (addr=0x203, opType=000, rdAddr=5), iMemRData=0x80FFFFFF → data granted first, oMemBe=1000, oRegOp={1,5,0xFFFFFF80}; fetch granted in the IDLE cycle after.
- Store half (addr=0x402, data=0x0000BEEF, opType=001) → oMemWe=1, oMemAddr=0x400, oMemBe=1100, oMemWData=0xBEEF0000; no oRegOp.
- Misaligned word load at 0x401 → oMisalign pulse, oMemReq stays 0, no oRegOp; lbu at 0x401 with lane 0xFF → 0x000000FF; load with rdAddr=0 → dv=0.
- iFlush mid-FETCH_WAIT, then ack → no oFetchDv; iFlush in the ack cycle → no oFetchDv; next fetch returns normally.
- iRstN low during LOAD_WAIT → oMemReq=0 and all outputs 0 immediately; after release, a new fetch is granted from IDLE.
